// File: rtl/apb_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_sub_pkg
// Brief    : Shared types for the registered APB subordinate bridge.
// Revision : 1.0
// ============================================================================
package apb_sub_pkg;

    localparam int APB_SUB_AW = 32;
    localparam int APB_SUB_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic                      write;
        logic [APB_SUB_AW-1:0]     addr;
        logic [APB_SUB_DW-1:0]     wdata;
        logic [APB_SUB_DW/8-1:0]   strb;
        logic [2:0]                prot;
    } apb_req_t;

    typedef struct packed {
        logic [APB_SUB_DW-1:0]     rdata;
        logic                      err;
    } apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_timer
// Brief    : Saturating busy-cycle counter; flags the edge that reaches the limit.
// Revision : 1.0
// ============================================================================
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_incr,
    output logic o_expired
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr && (r_count != c_limit)) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    // High when the next busy increment brings the count to the limit.
    assign o_expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/apb_subordinate_fsm.sv
`default_nettype none
// ============================================================================
// Module   : apb_subordinate_fsm
// Brief    : Registered APB subordinate driving single-strobe device requests.
//            Optional busy timeout enabled by APB_SUB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module apb_subordinate_fsm
    import apb_sub_pkg::*;
#(
    parameter int                    ADDR_WIDTH = APB_SUB_AW,
    parameter int                    DATA_WIDTH = APB_SUB_DW,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH:0]   RANGE_SIZE = (ADDR_WIDTH+1)'(4096),
    parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = '1
`ifdef APB_SUB_TIMEOUT_EN
    ,
    parameter int                    TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    wEn,
    output logic                    rEn,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [DATA_WIDTH-1:0]   wData,
    output logic [DATA_WIDTH/8-1:0] wStrb,
    output logic [2:0]              prot,
    input  logic [DATA_WIDTH-1:0]   rData,
    input  logic                    error,
    input  logic                    busy
);

    state_t                r_state;
    state_t                w_state_nxt;
    apb_req_t              r_req;
    apb_rsp_t              r_rsp;
    logic                  r_wen;
    logic                  r_ren;
    logic [ADDR_WIDTH-1:0] w_masked;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_hit;
    logic                  w_setup;
    logic                  w_access;
    logic                  w_timeout;

    assign w_setup  = psel & ~penable;
    assign w_access = psel & penable;

    // Subtraction first keeps the window check free of BASE+RANGE overflow.
    assign w_masked = paddr & ADDR_MASK;
    assign w_offset = w_masked - BASE_ADDR;
    assign w_hit    = (w_masked >= BASE_ADDR) && ({1'b0, w_offset} < RANGE_SIZE);

`ifdef APB_SUB_TIMEOUT_EN
    logic w_expired;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state != ISSUE),
        .i_incr    ((r_state == ISSUE) && busy),
        .o_expired (w_expired)
    );

    assign w_timeout = w_expired & busy;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_state_nxt = w_hit ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (!busy || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (w_access || !psel) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req <= '0;
            r_rsp <= '0;
            r_wen <= 1'b0;
            r_ren <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        if (w_hit) begin
                            r_req <= '{write: pwrite, addr: w_offset, wdata: pwdata,
                                       strb: pstrb, prot: pprot};
                            r_wen <= pwrite;
                            r_ren <= ~pwrite;
                        end else begin
                            r_rsp <= '{rdata: '0, err: 1'b1};
                        end
                    end
                end
                ISSUE: begin
                    if (!busy) begin
                        r_wen       <= 1'b0;
                        r_ren       <= 1'b0;
                        r_rsp.rdata <= r_req.write ? '0 : rData;
                        r_rsp.err   <= error;
                    end else if (w_timeout) begin
                        r_wen <= 1'b0;
                        r_ren <= 1'b0;
                        r_rsp <= '{rdata: '0, err: 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign pready  = (r_state == RESP) & w_access;
    assign prdata  = pready ? r_rsp.rdata : '0;
    assign pslverr = pready & r_rsp.err;

    assign wEn   = r_wen;
    assign rEn   = r_ren;
    assign addr  = r_req.addr;
    assign wData = r_req.wdata;
    assign wStrb = r_req.strb;
    assign prot  = r_req.prot;

endmodule
`default_nettype wire

// File: doc/apb_subordinate_fsm.md
Name: apb_subordinate_fsm

Overview:
- Registered APB subordinate bridge that converts APB transfers into single-strobe GenericBus-style device requests.
- Captures the APB setup phase and decodes the address window.
- Holds the device strobe until the device is not busy, then returns the captured response with PREADY/PSLVERR.
- Sits between the APB interconnect and one peripheral; successor of the combinational pass-through subordinate, adding wait states, decode errors and a timeout.

Parameters:
- AddrWidth, 32, APB/device address width.
- DataWidth, 32, data width; must be a multiple of 8.
- BaseAddr, 0, lowest address of the decoded window.
- RangeSize, 4096, window size in bytes; hit when BaseAddr <= (paddr & AddrMask) < BaseAddr+RangeSize.
- AddrMask, all ones, mask applied to paddr before decode.
- TimeoutCycles, 16, maximum busy cycles before an error response (only with APB_SUB_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB direction.
- paddr  in  AddrWidth  APB address.
- pwdata  in  DataWidth  APB write data.
- pstrb  in  DataWidth/8  APB write strobes.
- pprot  in  3  APB protection.
- prdata  out  DataWidth  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- wEn  out  1  device write strobe.
- rEn  out  1  device read strobe.
- addr  out  AddrWidth  device address, (paddr & AddrMask) - BaseAddr.
- wData  out  DataWidth  device write data.
- wStrb  out  DataWidth/8  device strobes.
- prot  out  3  device protection.
- rData  in  DataWidth  device read data.
- error  in  1  device error.
- busy  in  1  device busy.

Behaviour:
- Reset (async, active-high): state=IDLE. prdata, pready, pslverr, wEn, rEn, addr, wData, wStrb, prot all 0. Timer=0.
- Device outputs are registered; all are driven only from the captured request.
- IDLE:
  - On psel & !penable, capture pwrite, paddr, pwdata, pstrb, pprot.
  - Hit -> ISSUE. Miss -> RESP with err=1, rdata=0, and no device strobe ever.
  - Otherwise stay in IDLE.
- ISSUE:
  - wEn=write, rEn=!write, both held.
  - Each clock edge with busy=0: capture rData (0 for writes) and error, drop the strobe -> RESP.
  - Each edge with busy=1: stay and increment the timer.
- RESP:
  - pready=1 only when psel & penable; prdata/pslverr present the captured values and are 0 when pready=0.
  - Edge with psel & penable -> IDLE, clear the timer.
  - If psel drops before completion -> IDLE, response discarded.
- pready=0 in IDLE and ISSUE. Minimum latency is one APB wait state: setup, ISSUE with busy=0, then RESP completes.
- psel/penable changes during ISSUE do not abort the device access; it completes, then RESP applies the rule above.
- Address subtraction is modulo 2^AddrWidth.
- A back-to-back setup arriving on the RESP completion edge is not captured; it is taken in IDLE on the following cycle. APB holds setup until penable, so no transfer is lost.
- Reset mid-transfer: immediate IDLE, strobes deasserted, no response issued.

Optional Feature:
- Macro: APB_SUB_TIMEOUT_EN.
- Defined: in ISSUE, when the timer reaches TimeoutCycles with busy still 1, drop the strobe -> RESP with err=1, rdata=0. Timer width is $clog2(TimeoutCycles+1).
- Undefined: no timer logic; ISSUE waits on busy indefinitely.

Decomposition:
- Package apb_sub_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - request struct {write, addr, wdata, strb, prot};
  - response struct {rdata, err}.
- One sub-module, apb_wait_timer (clear, increment, expired flag), instantiated only under APB_SUB_TIMEOUT_EN.

Test Plan:
- Write 0xDEADBEEF to BaseAddr+0x10, strb 0xF, busy=0 -> one cycle of wEn=1 with addr=0x10 and wData=0xDEADBEEF; pready=1, pslverr=0 in the second ACCESS cycle.
- Read BaseAddr+0x4, busy=1 for 3 cycles, rData=0x12345678 -> rEn held 4 cycles; prdata=0x12345678 with pready; 3 extra wait states.
- Access to BaseAddr+RangeSize -> no wEn/rEn; pready=1, pslverr=1, prdata=0 at the first ACCESS cycle after decode.
- With APB_SUB_TIMEOUT_EN and TimeoutCycles=16, busy stuck at 1 -> strobe dropped after 16 busy cycles; pslverr=1, prdata=0.
- Device error=1 on acceptance of a read -> pslverr=1 and prdata = rData captured at acceptance.
- Reset asserted while in ISSUE -> all outputs 0 asynchronously; next transfer after reset completes normally.
